// File: rtl/mx_stream_arbiter_if.sv
// Handshake bundle between the element-stream requesters and the MX word output of the arbiter.
`timescale 1ns/1ps
interface mx_stream_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
) ();
    localparam int unsigned ELEM_W = 6;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned WORD_W = 8;
    localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ELEM_W-1:0] req_data;
    logic [NUM_REQ*EXP_W-1:0]  req_exp;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [WORD_W-1:0]         out_data;
    logic [EXP_W-1:0]          out_exp;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
    logic                      block_done;
    logic                      busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_exp, out_ready,
        output req_ready, out_valid, out_data, out_exp, out_src, block_done, busy
    );

    // Requester / sink side
    modport master (
        output req_valid, req_data, req_exp, out_ready,
        input  req_ready, out_valid, out_data, out_exp, out_src, block_done, busy
    );
endinterface

// File: rtl/mx_stream_arbiter.sv
// Round-robin block arbiter: grants whole MX blocks to one requester and emits {ctrl, elem} words.
`timescale 1ns/1ps
module mx_stream_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned BLOCK_SIZE = 32,
    parameter int unsigned ELEM_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mx_stream_arbiter_if.slave    bus
);
    localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned WORD_W = ELEM_WIDTH + 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    grant_q, grant_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    elem_cnt_q, elem_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [EXP_W-1:0]    out_exp_q, out_exp_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;

    logic                   sel_valid;
    logic [ELEM_WIDTH-1:0]  sel_data;
    logic [EXP_W-1:0]       sel_exp;
    logic                   scan_hit;
    logic [SRC_W-1:0]       scan_idx;
    int unsigned            scan_dist;
    int unsigned            best_dist;
    logic                   accept;
    logic [NUM_REQ-1:0]     req_ready_c;
    logic                   block_done_c;

    // Select the granted requester's element, valid and exponent
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_exp   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == SRC_W'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_data  = bus.req_data[i*ELEM_WIDTH +: ELEM_WIDTH];
                sel_exp   = bus.req_exp[i*EXP_W +: EXP_W];
            end
        end
    end

    // First valid requester at or after rr_ptr, by circular distance
    always_comb begin
        scan_idx  = '0;
        scan_dist = 0;
        best_dist = NUM_REQ;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_dist = (i + NUM_REQ - 32'(rr_ptr_q)) % NUM_REQ;
            if (bus.req_valid[i] && (scan_dist < best_dist)) begin
                best_dist = scan_dist;
                scan_idx  = SRC_W'(i);
            end
        end
        scan_hit = (best_dist < NUM_REQ);
    end

    // Next-state, output register load and handshake decode
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        elem_cnt_d   = elem_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_exp_d    = out_exp_q;
        out_src_d    = out_src_q;
        req_ready_c  = '0;
        block_done_c = 1'b0;
        accept       = !out_valid_q || bus.out_ready;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (scan_hit) begin
                    grant_d    = scan_idx;
                    elem_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == SRC_W'(i)) begin
                        req_ready_c[i] = accept;
                    end
                end
                if (sel_valid && accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {(elem_cnt_q == '0) ? 2'b01 : 2'b00, sel_data};
                    out_src_d   = grant_q;
                    if (elem_cnt_q == '0) begin
                        out_exp_d = sel_exp;
                    end
                    if (elem_cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
                        block_done_c = 1'b1;
                        state_d      = IDLE;
                        elem_cnt_d   = '0;
                        rr_ptr_d     = (grant_q == SRC_W'(NUM_REQ - 1)) ? '0 : grant_q + SRC_W'(1);
                    end else begin
                        elem_cnt_d = elem_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            elem_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_exp_q   <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            elem_cnt_q  <= elem_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_exp_q   <= out_exp_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.block_done = block_done_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_exp    = out_exp_q;
    assign bus.out_src    = out_src_q;
    assign bus.busy       = (state_q == BURST);

endmodule
